// File: rtl/seq_alu_pkg.sv
// Shared opcode and FSM state definitions for seq_alu.
// Build option: SEQ_ALU_MUL_EN adds the BUSY state used by the iterative multiplier.
package seq_alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR = 4'd4;
  localparam logic [OP_W-1:0] OP_SL  = 4'd5;
  localparam logic [OP_W-1:0] OP_SR  = 4'd6;
  localparam logic [OP_W-1:0] OP_SRA = 4'd7;
  localparam logic [OP_W-1:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef SEQ_ALU_MUL_EN
    ST_BUSY = 2'd1,
`endif
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the issuing stage (master) and seq_alu (slave).
interface seq_alu_if
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             illegal;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, carry, illegal
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, carry, illegal
  );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per clock, WIDTH clocks per product.
// Only compiled into the design when SEQ_ALU_MUL_EN is defined.
`ifdef SEQ_ALU_MUL_EN
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_d;

  always_comb begin
    acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  // done is combinational so the final partial sum is captured on the same edge as the last iteration.
  assign done    = busy_q && (cnt_q == LAST_ITER);
  assign product = acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle logic/arith/shift ops, optional iterative MUL.
// Build option: SEQ_ALU_MUL_EN enables MUL (opcode 8); otherwise opcode 8 reports illegal.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus
);

  localparam int SH_W = $clog2(WIDTH);

  state_e state_q, state_d;
  logic   accept;
  logic   sc_take;

  assign accept = bus.in_valid && (state_q == ST_IDLE);

`ifdef SEQ_ALU_MUL_EN
  logic               is_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign is_mul  = (bus.op == OP_MUL);
  assign sc_take = accept && !is_mul;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign sc_take = accept;
`endif

  // Single-cycle datapath, evaluated on the live inputs and captured on acceptance.
  logic [WIDTH-1:0] sc_result;
  logic             sc_carry;
  logic             sc_illegal;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic             shift_oob;
  logic [SH_W-1:0]  sh_amt;

  // NOTE: combinational blocks use blocking '=' and assign every output a default first so no latch is inferred.
  always_comb begin
    sum_ext    = {1'b0, bus.a} + {1'b0, bus.b};
    diff_ext   = {1'b0, bus.a} - {1'b0, bus.b};
    shift_oob  = |bus.b[WIDTH-1:SH_W];
    sh_amt     = bus.b[SH_W-1:0];
    sc_result  = '0;
    sc_carry   = 1'b0;
    sc_illegal = 1'b0;
    case (bus.op)
      OP_ADD: {sc_carry, sc_result} = sum_ext;
      OP_SUB: {sc_carry, sc_result} = diff_ext;
      OP_AND: sc_result = bus.a & bus.b;
      OP_OR:  sc_result = bus.a | bus.b;
      OP_XOR: sc_result = bus.a ^ bus.b;
      OP_SL:  sc_result = shift_oob ? '0 : (bus.a << sh_amt);
      OP_SR:  sc_result = shift_oob ? '0 : (bus.a >> sh_amt);
      OP_SRA: sc_result = shift_oob ? {WIDTH{bus.a[WIDTH-1]}}
                                    : WIDTH'($signed(bus.a) >>> sh_amt);
`ifdef SEQ_ALU_MUL_EN
      OP_MUL: sc_result = '0;
`endif
      default: sc_illegal = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
`ifdef SEQ_ALU_MUL_EN
          state_d = is_mul ? ST_BUSY : ST_DONE;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef SEQ_ALU_MUL_EN
      ST_BUSY: if (mul_done) state_d = ST_DONE;
`endif
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE);
    bus.out_valid = (state_q == ST_DONE);
  end

  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             carry_q;
  logic             illegal_q;

  // Result registers only load on acceptance or MUL completion, so they stay frozen through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q  <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (sc_take) begin
      result_q  <= sc_result;
      zero_q    <= (sc_result == '0);
      carry_q   <= sc_carry;
      illegal_q <= sc_illegal;
    end
`ifdef SEQ_ALU_MUL_EN
    else if (mul_done) begin
      result_q  <= mul_product[WIDTH-1:0];
      zero_q    <= (mul_product[WIDTH-1:0] == '0);
      carry_q   <= |mul_product[2*WIDTH-1:WIDTH];
      illegal_q <= 1'b0;
    end
`endif
  end

  assign bus.result  = result_q;
  assign bus.zero    = zero_q;
  assign bus.carry   = carry_q;
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed, table-driven bench for seq_alu at WIDTH=16, plus backpressure and reset-abort sequences.
// Expectations for opcode 8 follow SEQ_ALU_MUL_EN.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus();

  seq_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         ill;
    int           lat;
    int           hold;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

`ifdef SEQ_ALU_MUL_EN
  localparam int MUL_LAT = W;
`else
  localparam int MUL_LAT = 1;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] res, input logic z, input logic c,
                              input logic ill, input int lat, input int hold);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res;
    v.z = z; v.c = c; v.ill = ill; v.lat = lat; v.hold = hold;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  {31'd0, bus.in_ready},  32'd1);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_result"},    {16'd0, bus.result},    32'd0);
    check({tag, "_zero"},      {31'd0, bus.zero},      32'd0);
    check({tag, "_carry"},     {31'd0, bus.carry},     32'd0);
    check({tag, "_illegal"},   {31'd0, bus.illegal},   32'd0);
  endtask

  // Drive one request, let it be accepted on the next rising edge, then scramble the inputs.
  task automatic issue(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    check({tag, "_in_ready_idle"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op = 4'h1;
    bus.a  = W'($urandom);
    bus.b  = W'($urandom);
  endtask

  // Called at the first falling edge after acceptance; lat counts rising edges since acceptance.
  task automatic wait_valid(input string tag, output int lat);
    int   lat_v = 1;
    logic leak  = 1'b0;
    while (bus.out_valid !== 1'b1 && lat_v < 64) begin
      if (bus.in_ready !== 1'b0) leak = 1'b1;
      @(posedge clk);
      lat_v++;
      @(negedge clk);
    end
    check({tag, "_out_valid_seen"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_in_ready_busy"}, {31'd0, leak}, 32'd0);
    lat = lat_v;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    issue(tag, v.op, v.a, v.b);
    wait_valid(tag, lat);
    check({tag, "_latency"}, lat,                        v.lat);
    check({tag, "_result"},  {16'd0, bus.result},        {16'd0, v.res});
    check({tag, "_zero"},    {31'd0, bus.zero},          {31'd0, v.z});
    check({tag, "_carry"},   {31'd0, bus.carry},         {31'd0, v.c});
    check({tag, "_illegal"}, {31'd0, bus.illegal},       {31'd0, v.ill});
    check({tag, "_in_ready_done"}, {31'd0, bus.in_ready}, 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s_hold%0d_out_valid", tag, h), {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("%s_hold%0d_in_ready", tag, h),  {31'd0, bus.in_ready},  32'd0);
      check($sformatf("%s_hold%0d_result", tag, h),    {16'd0, bus.result},    {16'd0, v.res});
      check($sformatf("%s_hold%0d_flags", tag, h),
            {29'd0, bus.zero, bus.carry, bus.illegal}, {29'd0, v.z, v.c, v.ill});
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_in_ready_after_take"},  {31'd0, bus.in_ready},  32'd1);
    check({tag, "_out_valid_after_take"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = '0;
    bus.a         = '0;
    bus.b         = '0;

    //          op      a        b        res      z     c     ill   lat      hold
    vecs.push_back(mk(OP_ADD, 16'h0002, 16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0, 1,       0));
    vecs.push_back(mk(OP_ADD, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 1,       0));
    vecs.push_back(mk(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1,       0));
    vecs.push_back(mk(OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1,       0));
    vecs.push_back(mk(OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0, 1,       0));
    vecs.push_back(mk(OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0, 1,       0));
    vecs.push_back(mk(OP_OR,  16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1,       0));
    vecs.push_back(mk(OP_XOR, 16'hFFFF, 16'h00FF, 16'hFF00, 1'b0, 1'b0, 1'b0, 1,       0));
    vecs.push_back(mk(OP_SL,  16'h0002, 16'h0003, 16'h0010, 1'b0, 1'b0, 1'b0, 1,       0));
    vecs.push_back(mk(OP_SL,  16'h0002, 16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0, 1,       0));
    vecs.push_back(mk(OP_SL,  16'h0002, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, 1,       0));
    vecs.push_back(mk(OP_SL,  16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 1'b0, 1,       0));
    vecs.push_back(mk(OP_SR,  16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0, 1,       0));
    vecs.push_back(mk(OP_SR,  16'h8000, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, 1,       0));
    vecs.push_back(mk(OP_SRA, 16'h8000, 16'h0014, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1,       0));
    vecs.push_back(mk(OP_SRA, 16'h8000, 16'h0004, 16'hF800, 1'b0, 1'b0, 1'b0, 1,       0));
    vecs.push_back(mk(OP_SRA, 16'h4000, 16'h0014, 16'h0000, 1'b1, 1'b0, 1'b0, 1,       0));
    vecs.push_back(mk(OP_SRA, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 1,       0));
`ifdef SEQ_ALU_MUL_EN
    vecs.push_back(mk(OP_MUL, 16'd300,  16'd300,  16'h5F90, 1'b0, 1'b1, 1'b0, MUL_LAT, 0));
    vecs.push_back(mk(OP_MUL, 16'd3,    16'd4,    16'h000C, 1'b0, 1'b0, 1'b0, MUL_LAT, 0));
    vecs.push_back(mk(OP_MUL, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, MUL_LAT, 0));
`else
    vecs.push_back(mk(OP_MUL, 16'd300,  16'd300,  16'h0000, 1'b1, 1'b0, 1'b1, MUL_LAT, 0));
`endif
    vecs.push_back(mk(4'hF,   16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0, 1'b1, 1,       0));
    vecs.push_back(mk(4'h9,   16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, 1,       0));
    // Backpressure: SUB result held five cycles in DONE before being taken.
    vecs.push_back(mk(OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1,       5));

    @(negedge clk);
    check_reset_outputs("rst_held");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec($sformatf("v%0d_op%0h", i, vecs[i].op), vecs[i]);
    end

    // Reset while a result waits in DONE: it must vanish and never reappear.
    issue("rst_done", OP_ADD, 16'hFFFF, 16'h0001);
    check("rst_done_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    check("rst_done_pre_carry", {31'd0, bus.carry},     32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_done_async");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_done_after");
    run_vec("rst_done_add", mk(OP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1, 0));

`ifdef SEQ_ALU_MUL_EN
    // Reset in the middle of a MUL, at iteration 7.
    issue("rst_mul", OP_MUL, 16'd300, 16'd300);
    repeat (7) @(posedge clk);
    check("rst_mul_busy_in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("rst_mul_busy_out_valid", {31'd0, bus.out_valid}, 32'd0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mul_async");
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 2) @(negedge clk);
    check_reset_outputs("rst_mul_after");
    run_vec("rst_mul_add", mk(OP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1, 0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the single-cycle combinational ALU. It accepts one operation at a time over a valid/ready input port and returns a registered result with flags over a valid/ready output port. Single-cycle ops take one clock; MUL is an iterative shift-add taking WIDTH clocks. It sits between the decode/register-read stage and writeback, and the control FSM stalls on `in_ready`/`out_valid`.

## Interface
- `WIDTH`, default 16: operand and result width; must be ≥ 4 and a power of two.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `op`  in  4  opcode; encoding is in the shared defines.
- `a`, `b`  in  WIDTH  operands.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  result == 0.
- `carry`  out  1  ADD carry-out, SUB borrow, or MUL high-half nonzero; 0 for other ops.
- `illegal`  out  1  opcode unsupported; result forced to 0.

## Operation
- Opcodes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SL=5, SR=6, SRA=7, MUL=8. Codes 9–15 are illegal.
- Arithmetic is modulo 2^WIDTH and unsigned. SUB carry = (a < b).
- Shifts: amount is the full `b` value. An amount ≥ WIDTH gives 0 for SL and SR, and replicates the sign bit for SRA. An amount of 0 passes `a` through.
- MUL: `result` holds the low WIDTH bits of the unsigned product. `carry` = 1 when the high WIDTH bits are nonzero.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, latch `op`, `a` and `b`. A non-MUL op (including illegal) computes and goes to DONE. MUL goes to BUSY.
  - BUSY: each cycle, examine one multiplier bit (LSB first), conditionally add the shifted multiplicand, and increment the counter. After WIDTH iterations, go to DONE.
  - DONE: `out_valid`=1. `result` and flags are held stable. On `out_ready`, go to IDLE.
- `in_ready` is low in BUSY and DONE, so input is not accepted in the same cycle a result is consumed. Peak throughput is one op per 2 clocks.
- Input values are ignored outside IDLE. Changes to `op`, `a` or `b` after acceptance do not affect the result.
- `out_ready` is ignored when `out_valid` is low.

## Timing
- Reset values: state=IDLE; `in_ready`=1; `out_valid`=0; `result`=0; `zero`=0; `carry`=0; `illegal`=0; counter=0.
- A single-cycle op accepted at edge k has `out_valid` high after edge k (latency 1).
- A MUL accepted at edge k has `out_valid` high after edge k+WIDTH.
- A result accepted (`out_valid` && `out_ready`) at edge j gives `in_ready` high after edge j.
- Asserting `rst` mid-BUSY or mid-DONE discards the operation immediately and returns all outputs to reset values. No result is produced for it.
- Iteration counter width is $clog2(WIDTH+1). Partial-product accumulator width is 2·WIDTH.

## Configuration
- `SEQ_ALU_MUL_EN` defined: MUL is supported as described above, and the multiplier sub-module is instantiated.
- `SEQ_ALU_MUL_EN` undefined: no multiplier logic and no BUSY state. Opcode 8 is illegal: latency 1, `result`=0, `illegal`=1. All other ops are unchanged.

## Structure
- Shared defines/package holds:
  - the op-width constant (4) and opcode constants, extending the existing ALU op constant set with SUB, AND, OR, XOR, SR, SRA and MUL;
  - the FSM state encodings.
- Sub-module `alu_mul_iter`: start/done handshake, WIDTH parameter, owns the counter and the 2·WIDTH accumulator. All single-cycle datapath and the handshake FSM stay in `seq_alu`.

## Test plan
Bench uses WIDTH=16.
- ADD a=2, b=0 → 2. ADD a=2, b=3 → 5, `carry`=0, `out_valid` one cycle after acceptance.
- SL a=2, b=3 → 0x0010. SL b=0 → 2. SL b=16 → 0. SRA a=0x8000, b=20 → 0xFFFF.
- SUB a=3, b=5 → 0xFFFE, `carry`=1. SUB a=5, b=5 → 0, `zero`=1.
- MUL a=300, b=300 → 0x5F90, `carry`=1, `out_valid` exactly 16 edges after acceptance, `in_ready`=0 throughout.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `result`/flags stable, `in_ready`=0. Then `out_ready`=1 → IDLE next cycle. Opcode 0xF → `illegal`=1, `result`=0.
- Reset mid-MUL at iteration 7 → all outputs at reset values, `in_ready`=1, and a following ADD 1+1 → 2.
